// File: rtl/mac_filter.sv
// Receive-path destination address filter: answers a compare request with an
// accept/drop verdict using promiscuous, multicast, broadcast and table rules.
module mac_filter #(
  parameter int unsigned NUM_ENTRIES = 14,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mac_rdy_i,
  input  logic [47:0]      mac_data_i,
  input  logic             mcast_i,
  input  logic             promis_i,
  input  logic             tbl_we_i,
  input  logic             tbl_clr_i,
  input  logic [IDX_W-1:0] tbl_idx_i,
  input  logic [47:0]      tbl_mac_i,
  output logic             cmp_done_o,
  output logic             cmp_res_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SCAN,
    DONE
  } state_t;

  state_t                 state;
  logic                   rdy_q;
  logic                   start;
  logic [47:0]            addr_r;
  logic [IDX_W-1:0]       idx;
  logic [47:0]            entry_mac [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;
  logic                   wr_ok;
  logic                   fast_ok;
  logic                   entry_hit;
  logic                   last_idx;

  assign start     = mac_rdy_i & ~rdy_q;
  assign wr_ok     = tbl_we_i && (32'(tbl_idx_i) < NUM_ENTRIES);
  assign fast_ok   = promis_i || (addr_r == '1) || (mcast_i && addr_r[40]);
  assign entry_hit = valid[idx] && (entry_mac[idx] == addr_r);
  assign last_idx  = (idx == IDX_W'(NUM_ENTRIES - 1));

  // Clear has priority over a same-cycle write, so the written entry stays invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i || tbl_clr_i) begin
      valid <= '0;
    end else if (wr_ok) begin
      valid[tbl_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !tbl_clr_i) begin
      entry_mac[tbl_idx_i] <= tbl_mac_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      addr_r     <= '0;
      idx        <= '0;
      cmp_done_o <= 1'b0;
      cmp_res_o  <= 1'b0;
      hit_idx_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      rdy_q      <= mac_rdy_i;
      cmp_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_r <= mac_data_i;
            busy_o <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (fast_ok) begin
            cmp_res_o  <= 1'b1;
            hit_idx_o  <= '0;
            cmp_done_o <= 1'b1;
            state      <= DONE;
          end else begin
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (entry_hit) begin
            cmp_res_o  <= 1'b1;
            hit_idx_o  <= idx;
            cmp_done_o <= 1'b1;
            state      <= DONE;
          end else if (last_idx) begin
            cmp_res_o  <= 1'b0;
            hit_idx_o  <= '0;
            cmp_done_o <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_filter.sv
// Directed bench for mac_filter: literal latency/verdict checks per request plus
// a per-cycle comparison against a rule-level behavioural model.
module tb_mac_filter;
  localparam int N = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        mac_rdy;
  logic [47:0] mac_data;
  logic        mcast;
  logic        promis;
  logic        tbl_we;
  logic        tbl_clr;
  logic [3:0]  tbl_idx;
  logic [47:0] tbl_mac;
  logic        cmp_done;
  logic        cmp_res;
  logic [3:0]  hit_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mac_filter #(.NUM_ENTRIES(N), .IDX_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .mac_rdy_i(mac_rdy), .mac_data_i(mac_data),
    .mcast_i(mcast), .promis_i(promis), .tbl_we_i(tbl_we), .tbl_clr_i(tbl_clr),
    .tbl_idx_i(tbl_idx), .tbl_mac_i(tbl_mac), .cmp_done_o(cmp_done),
    .cmp_res_o(cmp_res), .hit_idx_o(hit_idx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: request lifecycle stage 0 idle, 1 awaiting mode check,
  // 2 walking the table at entry m_k, 3 verdict cycle.
  int          m_stage = 0;
  int          m_k = 0;
  logic [47:0] m_addr = '0;
  bit          m_valid [N];
  logic [47:0] m_mac [N];
  bit          m_prev = 0;
  bit          e_res = 0;
  int          e_hit = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_stage = 0;
      e_res   = 0;
      e_hit   = 0;
      m_prev  = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else begin
      case (m_stage)
        0: if (mac_rdy && !m_prev) begin
             m_addr  = mac_data;
             m_stage = 1;
           end
        1: if (promis || m_addr == 48'hFFFF_FFFF_FFFF || (mcast && m_addr[40])) begin
             e_res = 1; e_hit = 0; m_stage = 3;
           end else begin
             m_k = 0; m_stage = 2;
           end
        2: if (m_valid[m_k] && m_mac[m_k] == m_addr) begin
             e_res = 1; e_hit = m_k; m_stage = 3;
           end else if (m_k == N - 1) begin
             e_res = 0; e_hit = 0; m_stage = 3;
           end else begin
             m_k++;
           end
        default: m_stage = 0;
      endcase
      if (tbl_clr) begin
        for (int i = 0; i < N; i++) m_valid[i] = 0;
      end else if (tbl_we && int'(tbl_idx) < N) begin
        m_valid[tbl_idx] = 1;
        m_mac[tbl_idx]   = tbl_mac;
      end
      m_prev = mac_rdy;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_done", 64'(cmp_done), 64'(m_stage == 3));
      chk("model_busy", 64'(busy), 64'(m_stage != 0));
      chk("model_res", 64'(cmp_res), 64'(e_res));
      chk("model_hit", 64'(hit_idx), 64'(e_hit));
    end
  end

  task automatic tbl_write(input int idx, input logic [47:0] mac, input bit with_clr);
    tbl_we  = 1'b1;
    tbl_idx = 4'(idx);
    tbl_mac = mac;
    tbl_clr = with_clr;
    @(posedge clk); #1;
    tbl_we  = 1'b0;
    tbl_clr = 1'b0;
  endtask

  task automatic clear_tbl();
    tbl_clr = 1'b1;
    @(posedge clk); #1;
    tbl_clr = 1'b0;
  endtask

  // Raises mac_rdy and counts edges (first sampling edge = 1) until cmp_done.
  // clr_edge > 0 pulses tbl_clr so it is sampled on that edge count.
  task automatic request(input string name, input logic [47:0] addr, input int exp_lat,
                         input bit exp_res, input int exp_hit, input int clr_edge);
    int n = 0;
    bit seen = 0;
    mac_data = addr;
    mac_rdy  = 1'b1;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = cmp_done;
      tbl_clr = (clr_edge > 0 && n + 1 == clr_edge);
    end
    tbl_clr = 1'b0;
    chk({name, "_seen"}, 64'(seen), 64'd1);
    chk({name, "_lat"}, 64'(n), 64'(exp_lat));
    chk({name, "_res"}, 64'(cmp_res), 64'(exp_res));
    chk({name, "_hit"}, 64'(hit_idx), 64'(exp_hit));
    mac_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    int done_at;
    rst = 1'b1; mac_rdy = 0; mac_data = '0; mcast = 0; promis = 0;
    tbl_we = 0; tbl_clr = 0; tbl_idx = '0; tbl_mac = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_done", 64'(cmp_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res", 64'(cmp_res), 64'd0);
    chk("rst_hit", 64'(hit_idx), 64'd0);
    @(posedge clk); #1;

    promis = 1'b1;
    request("promis", 48'h0200_0000_0001, 2, 1, 0, 0);
    promis = 1'b0;

    tbl_write(5, 48'hAA00_0400_1234, 0);
    request("match5", 48'hAA00_0400_1234, 8, 1, 5, 0);

    clear_tbl();
    request("miss", 48'h0800_2B01_0203, 16, 0, 0, 0);
    request("bcast", 48'hFFFF_FFFF_FFFF, 2, 1, 0, 0);

    request("mc_off", 48'h0100_5E00_0001, 16, 0, 0, 0);
    mcast = 1'b1;
    request("mc_on", 48'h0100_5E00_0001, 2, 1, 0, 0);
    mcast = 1'b0;

    tbl_write(0, 48'h1234_5678_9ABC, 0);
    request("match0", 48'h1234_5678_9ABC, 3, 1, 0, 0);

    tbl_write(13, 48'hDEAD_BEEF_0013, 0);
    request("match13", 48'hDEAD_BEEF_0013, 16, 1, 13, 0);
    request("clr_scan", 48'hDEAD_BEEF_0013, 16, 0, 0, 5);

    tbl_write(2, 48'h0022_3344_5566, 1);
    request("we_clr", 48'h0022_3344_5566, 16, 0, 0, 0);

    tbl_write(14, 48'h0077_0000_0014, 0);
    request("idx_oor", 48'h0077_0000_0014, 16, 0, 0, 0);

    mac_data = 48'h0800_2B0A_0B0C;
    mac_rdy  = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(cmp_done), 64'd0);
    rst = 1'b0;
    mac_rdy = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cmp_done) dones++;
    end
    chk("rstmid_nodone", 64'(dones), 64'd0);

    dones = 0;
    done_at = 0;
    mac_rdy = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (cmp_done) begin
        dones++;
        done_at = n;
      end
      if (n == 3) mac_rdy = 1'b0;
      if (n == 5) mac_rdy = 1'b1;
    end
    mac_rdy = 1'b0;
    chk("dbl_count", 64'(dones), 64'd1);
    chk("dbl_lat", 64'(done_at), 64'd16);
    repeat (3) @(posedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
